regbank_writeback: RTL

- Write-side counterpart of the CPU's 4-way operand data selector.
- Takes one WIDTH-bit result and writes it into one of four destination registers chosen by a 2-bit select: A (0), B (1), OUT (2), PC (3).
- The four register values are exported as q0..q3 and feed the selector's c0..c3 inputs on the next instruction.
- The PC slot auto-increments on every enabled step in which it is not explicitly loaded.

---
 rtl/regbank_writeback.sv | 86 ++++++++
 1 files changed

// File: rtl/regbank_writeback.sv
// Write-back register bank: A/B/OUT/PC slots with an auto-incrementing PC.
// Optional pc_wrap output is enabled by defining REGBANK_PC_WRAP_EN.
module regbank_writeback #(
    parameter int unsigned      WIDTH      = 4,
    parameter logic [WIDTH-1:0] PC_RST_VAL = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             we,
    input  logic [1:0]       sel,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q0,
    output logic [WIDTH-1:0] q1,
    output logic [WIDTH-1:0] q2,
    output logic [WIDTH-1:0] q3,
    output logic             out_stb
`ifdef REGBANK_PC_WRAP_EN
    ,
    output logic             pc_wrap
`endif
);

    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] out_q, out_d;
    logic [WIDTH-1:0] pc_q, pc_d;
    logic             out_stb_q, out_stb_d;
    logic             pc_load;

    // An explicit PC write always wins over the increment, even if d equals PC.
    assign pc_load = we && (sel == 2'd3);

    always_comb begin
        a_d       = a_q;
        b_d       = b_q;
        out_d     = out_q;
        pc_d      = pc_q;
        out_stb_d = 1'b0;
        if (en) begin
            if (we && (sel == 2'd0)) a_d   = d;
            if (we && (sel == 2'd1)) b_d   = d;
            if (we && (sel == 2'd2)) out_d = d;
            pc_d      = pc_load ? d : pc_q + WIDTH'(1);
            out_stb_d = we && (sel == 2'd2);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_q       <= '0;
            b_q       <= '0;
            out_q     <= '0;
            pc_q      <= PC_RST_VAL;
            out_stb_q <= 1'b0;
        end else begin
            a_q       <= a_d;
            b_q       <= b_d;
            out_q     <= out_d;
            pc_q      <= pc_d;
            out_stb_q <= out_stb_d;
        end
    end

`ifdef REGBANK_PC_WRAP_EN
    logic pc_wrap_q, pc_wrap_d;

    always_comb begin
        pc_wrap_d = en && !pc_load && (pc_q == '1);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) pc_wrap_q <= 1'b0;
        else     pc_wrap_q <= pc_wrap_d;
    end

    assign pc_wrap = pc_wrap_q;
`endif

    assign q0      = a_q;
    assign q1      = b_q;
    assign q2      = out_q;
    assign q3      = pc_q;
    assign out_stb = out_stb_q;

endmodule
